// File: rtl/pwm_gen_axi_slave.sv
// pwm_gen_axi_slave: AXI4-Lite CTRL/PERIOD/DUTY/PRESCALE registers driving a prescaled PWM core.
// Define PWM_GEN_SHADOW_EN to double-buffer PERIOD/DUTY until period end (or while disabled).
module pwm_gen_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              pwm_out,
  output logic                              period_end
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  typedef enum logic [1:0] {W_IDLE, W_WAIT_D, W_WAIT_A, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [1:0] aw_sel, wr_sel;
  logic [DW-1:0] w_data_q, wr_data;
  logic [DW/8-1:0] w_strb_q, wr_strb;
  logic [DW-1:0] regs [4];
  logic [DW-1:0] period_a, duty_a, pre_cnt, cnt;
  logic aw_hs, w_hs, ar_hs, wr_en, en, tick, wrap, unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign aw_hs = S_AXI_AWREADY & S_AXI_AWVALID;
  assign w_hs = S_AXI_WREADY & S_AXI_WVALID;
  assign ar_hs = S_AXI_ARREADY & S_AXI_ARVALID;
  assign wr_en = w_state == W_WAIT_D ? w_hs : w_state == W_WAIT_A ? aw_hs : (w_state == W_IDLE) && aw_hs && w_hs;
  assign wr_sel = w_state == W_WAIT_D ? aw_sel : S_AXI_AWADDR[3:2];
  assign wr_data = w_state == W_WAIT_A ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_state == W_WAIT_A ? w_strb_q : S_AXI_WSTRB;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      aw_sel <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            w_state <= W_RESP;
          end else if (aw_hs) begin
            aw_sel <= S_AXI_AWADDR[3:2];
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY <= 1'b1;
            w_state <= W_WAIT_D;
          end else if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY <= 1'b0;
            w_state <= W_WAIT_A;
          end else begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY <= 1'b1;
          end
        end
        W_WAIT_D: if (w_hs) begin
          S_AXI_WREADY <= 1'b0;
          S_AXI_BVALID <= 1'b1;
          w_state <= W_RESP;
        end
        W_WAIT_A: if (aw_hs) begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_BVALID <= 1'b1;
          w_state <= W_RESP;
        end
        W_RESP: if (S_AXI_BREADY) begin
          S_AXI_BVALID <= 1'b0;
          S_AXI_AWREADY <= 1'b1;
          S_AXI_WREADY <= 1'b1;
          w_state <= W_IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
    end else if (r_state == R_IDLE) begin
      S_AXI_ARREADY <= ~ar_hs;
      if (ar_hs) begin
        S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
        S_AXI_RVALID <= 1'b1;
        r_state <= R_DATA;
      end
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
      r_state <= R_IDLE;
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) regs <= '{default: '0};
    else if (wr_en)
      for (int b = 0; b < DW/8; b++)
        if (wr_strb[b]) regs[wr_sel][8*b +: 8] <= wr_data[8*b +: 8];
  end
`ifdef PWM_GEN_SHADOW_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      period_a <= '0;
      duty_a <= '0;
    end else if (!en || wrap) begin
      period_a <= regs[1];
      duty_a <= regs[2];
    end
  end
`else
  assign period_a = regs[1];
  assign duty_a = regs[2];
`endif
  assign en = regs[0][0];
  // >= rather than == so a PERIOD/PRESCALE lowered below the running count still wraps
  assign tick = pre_cnt >= regs[3];
  assign wrap = tick && cnt >= period_a;
  always_ff @(posedge ACLK) begin
    if (ARESET || !en) begin
      pre_cnt <= '0;
      cnt <= '0;
      pwm_out <= 1'b0;
      period_end <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      cnt <= tick ? (wrap ? '0 : cnt + 1'b1) : cnt;
      pwm_out <= (cnt < duty_a) ^ regs[0][1];
      period_end <= wrap;
    end
  end
endmodule

// File: tb/tb_pwm_gen_axi_slave.sv
// tb_pwm_gen_axi_slave: directed vector table plus hand-written AXI/PWM sequences for pwm_gen_axi_slave.
module tb_pwm_gen_axi_slave;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [3:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0] S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0] S_AXI_WSTRB = '0;
  logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, pwm_out, period_end;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;
`ifdef PWM_GEN_SHADOW_EN
  localparam int DUTY_CHG_HI = 3;
`else
  localparam int DUTY_CHG_HI = 6;
`endif
  pwm_gen_axi_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .pwm_out(pwm_out), .period_end(period_end)
  );
  always #5 ACLK = ~ACLK;
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  int tests = 0, fails = 0;
  logic pwm_s [64];
  logic pe_s [64];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ah, wh, got;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    for (int i = 0; i < 20 && (S_AXI_AWVALID || S_AXI_WVALID); i++) begin
      ah = S_AXI_AWVALID && S_AXI_AWREADY;
      wh = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      if (ah) S_AXI_AWVALID = 0;
      if (wh) S_AXI_WVALID = 0;
    end
    check("write_accepted", {S_AXI_AWVALID, S_AXI_WVALID}, 0);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (S_AXI_BVALID) begin
        got = 1;
        check("bresp_okay", S_AXI_BRESP, 0);
      end
      @(negedge ACLK);
    end
    S_AXI_BREADY = 0;
    check("bvalid_seen", got, 1);
  endtask
  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    logic h, got;
    d = 'x;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
    for (int i = 0; i < 20 && S_AXI_ARVALID; i++) begin
      h = S_AXI_ARREADY;
      @(negedge ACLK);
      if (h) S_AXI_ARVALID = 0;
    end
    S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (S_AXI_RVALID) begin
        got = 1;
        d = S_AXI_RDATA;
        check("rresp_okay", S_AXI_RRESP, 0);
      end
      @(negedge ACLK);
    end
    S_AXI_RREADY = 0;
    check("rvalid_seen", got, 1);
  endtask
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      pwm_s[i] = pwm_out;
      pe_s[i] = period_end;
    end
  endtask
  // Expect a 10-clock period: hi cycles of raw high after each period_end, optionally inverted
  task automatic check_wave(input string name, input int hi, input bit inv);
    int p, errs;
    p = -1; errs = 0;
    capture(45);
    for (int i = 0; i < 20 && p < 0; i++) if (pe_s[i]) p = i;
    check({name, "_pe_found"}, p >= 0, 1);
    if (p >= 0)
      for (int j = 1; j <= 20; j++) begin
        errs += int'(pwm_s[p+j] !== ((((j-1) % 10) < hi) ^ inv));
        errs += int'(pe_s[p+j] !== (j % 10 == 0));
      end
    check({name, "_wave_errors"}, errs, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl [8];
    logic [31:0] rd;
    int errs;
    logic found;
    tbl[0] = '{4'h0, 32'h0000_0001, 4'hf, 32'h0000_0001};
    tbl[1] = '{4'h4, 32'h0000_0002, 4'hf, 32'h0000_0002};
    tbl[2] = '{4'h8, 32'h0000_0003, 4'hf, 32'h0000_0003};
    tbl[3] = '{4'hc, 32'h0000_0004, 4'hf, 32'h0000_0004};
    tbl[4] = '{4'h4, 32'hAABB_CCDD, 4'h5, 32'h00BB_00DD};
    tbl[5] = '{4'hc, 32'hFFFF_FFFF, 4'h0, 32'h0000_0004};
    tbl[6] = '{4'h8, 32'h1122_3344, 4'ha, 32'h1100_3303};
    tbl[7] = '{4'h0, 32'hFFFF_FF00, 4'h1, 32'h0000_0000};
    repeat (3) @(negedge ACLK);
    check("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, pwm_out, period_end}, 0);
    check("reset_rdata", S_AXI_RDATA, 0);
    check("reset_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
    ARESET = 0;
    @(negedge ACLK);
    check("readies_after_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    for (int i = 0; i < 8; i++) begin
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      axi_read(tbl[i].addr, rd);
      check($sformatf("vec%0d_readback", i), rd, tbl[i].exp);
    end
    // W leads AW by three cycles; B held off for five cycles with a second AW waiting
    @(negedge ACLK);
    S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hf; S_AXI_WVALID = 1;
    check("wfirst_wready", S_AXI_WREADY, 1);
    @(negedge ACLK);
    S_AXI_WVALID = 0;
    check("wfirst_wait_a_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b10);
    repeat (2) @(negedge ACLK);
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1;
    @(negedge ACLK);
    check("wfirst_bvalid", S_AXI_BVALID, 1);
    S_AXI_AWADDR = 4'h4;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      errs += int'(S_AXI_BVALID !== 1'b1) + int'(S_AXI_AWREADY !== 1'b0);
      @(negedge ACLK);
    end
    check("wfirst_b_held_aw_blocked", errs, 0);
    S_AXI_BREADY = 1;
    @(negedge ACLK);
    S_AXI_BREADY = 0; S_AXI_AWVALID = 0;
    check("wfirst_b_done", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b01);
    axi_read(4'h8, rd);
    check("wfirst_duty", rd, 32'h55);
    axi_read(4'h4, rd);
    check("wfirst_period_untouched", rd, 32'h00BB_00DD);
    axi_write(4'h4, 9, 4'hf);
    axi_write(4'h8, 3, 4'hf);
    axi_write(4'hc, 0, 4'hf);
    axi_write(4'h0, 1, 4'hf);
    check_wave("pwm_3hi", 3, 0);
    axi_write(4'h0, 3, 4'hf);
    check_wave("pwm_inv", 3, 1);
    axi_write(4'h0, 1, 4'hf);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge ACLK);
      found = period_end;
    end
    check("dutychg_pe_found", found, 1);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 6; S_AXI_WSTRB = 4'hf;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
    check("dutychg_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    for (int j = 1; j <= 10; j++) begin
      @(negedge ACLK);
      if (j == 1) begin S_AXI_AWVALID = 0; S_AXI_WVALID = 0; end
      pwm_s[j] = pwm_out;
    end
    S_AXI_BREADY = 0;
    errs = 0;
    for (int j = 1; j <= 10; j++) errs += int'(pwm_s[j] !== (j <= DUTY_CHG_HI));
    check("dutychg_wave_errors", errs, 0);
    axi_write(4'h0, 0, 4'hf);
    axi_write(4'hc, 1, 4'hf);
    axi_write(4'h4, 4, 4'hf);
    axi_write(4'h8, 5, 4'hf);
    axi_write(4'h0, 1, 4'hf);
    check_wave("presc_const_high", 10, 0);
    axi_write(4'h8, 0, 4'hf);
    check_wave("duty0_const_low", 0, 0);
    axi_write(4'h8, 5, 4'hf);
    capture(3);
    check("pre_reset_pwm", pwm_out, 1);
    @(negedge ACLK);
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    check("pre_reset_rvalid", S_AXI_RVALID, 1);
    ARESET = 1;
    @(negedge ACLK);
    check("mid_reset_outputs", {S_AXI_RVALID, S_AXI_BVALID, pwm_out, period_end}, 0);
    ARESET = 0;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      check($sformatf("post_reset_reg%0d", i), rd, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
